uart_tx_module: RTL

- Serial transmitter back toward the host. It is the return path for the configuration link: it sends status and echo bytes produced by the control logic.
- Bytes are queued in a small FIFO and serialised as 8N1 UART frames, LSB first, at a fixed baud rate derived from the 100 MHz main clock.
- It sits beside the receive/parse path in the ABCD output top level and drives the board's TX pin.

---
 rtl/uart_tx_module.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_module.sv
// uart_tx_module
//   Return-path UART transmitter. Bytes written by the control logic are
//   held in a small FIFO and sent as 8N1 frames, LSB first, each bit held
//   for CLK_DIV clock cycles. When the FIFO still holds a byte at the end
//   of a stop bit, the next start bit follows immediately, with no idle gap.
//
//   Optional build macro: UART_TX_PARITY_EN
//     When defined, an even-parity bit (XOR of the 8 data bits) is inserted
//     between the last data bit and the stop bit, giving 11-bit frames.
//
// Parameters
//   CLK_DIV  clock cycles per bit (>= 2)
//   FIFO_AW  FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk         main clock
//   rst         synchronous active-high reset
//   tx_data_in  byte to enqueue
//   tx_wr       enqueue strobe
//   fifo_full   FIFO holds 2**FIFO_AW bytes
//   fifo_empty  FIFO holds no bytes
//   fifo_level  current byte count
//   tx_ovf      sticky: a write was dropped on a full FIFO
//   tx_busy     a frame is in progress
//   tx_done     one-cycle pulse in the last cycle of each stop bit
//   tx_pin_out  serial line, idle high
module uart_tx_module #(
  parameter int CLK_DIV = 868,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         tx_data_in,
  input  logic               tx_wr,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               tx_ovf,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               tx_pin_out
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(CLK_DIV - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_ovf;

  // Serialiser
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_done;
`ifdef UART_TX_PARITY_EN
  logic               r_par;
`endif

  logic               w_full;
  logic               w_empty;
  logic               w_bit_end;
  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_head;

  // Level never exceeds DEPTH, so its MSB alone marks "full".
  assign w_full    = r_level[FIFO_AW];
  assign w_empty   = (r_level == '0);
  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_head    = r_mem[r_rptr];

  // A byte leaves the FIFO when the line is idle, or in the last stop-bit
  // cycle so the next start bit follows without a gap.
  assign w_pop  = !w_empty &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  // Full is judged on the registered level: a same-cycle pop does not
  // rescue a write that arrives while full.
  assign w_push = tx_wr && !w_full;

  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign fifo_level = r_level;
  assign tx_ovf     = r_ovf;
  assign tx_busy    = (r_state != S_IDLE);
  assign tx_done    = r_done;
  assign tx_pin_out = r_tx;

  // Storage array carries no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (tx_wr && w_full) r_ovf <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      // Registered one cycle ahead so the pulse lands on the last stop cycle.
      r_done <= (r_state == S_STOP) && (r_cnt == CNT_PREV);

      if (r_state != S_IDLE) r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^w_head;
`endif
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
              // Next data bit is the one about to shift into position 0.
              r_tx  <= r_shift[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
              r_par   <= ^w_head;
`endif
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
